// File: rtl/rr_sel_4_pkg.sv
// Shared types and constants for the 4-way round-robin grant scheduler.
package rr_sel_4_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int IW = 2;
  localparam logic [IW-1:0] RST_PTR = 2'd3;

  // Modulo-4 rotation of an index; the natural 2-bit wrap does the mod.
  function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] base,
                                            input logic [IW-1:0] off);
    return base + off;
  endfunction

endpackage

// File: rtl/rr_sel_4_pick.sv
// Rotating-priority picker: first set request after 'last', wrapping, with 'last' itself lowest.
module rr_pick_4
  import rr_sel_4_pkg::*;
(
  input  logic [3:0]    req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] w_cand;

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    idx    = last;
    any    = 1'b0;
    w_cand = last;
    for (int k = 3; k >= 0; k--) begin
      w_cand = rot_idx(last, IW'(k + 1));
      if (req[w_cand]) begin
        idx = w_cand;
        any = 1'b1;
      end else begin
        idx = idx;
        any = any;
      end
    end
  end

endmodule

// File: rtl/rr_sel_4.sv
// Round-robin scheduler driving a 2-to-4 decoder: bounded grant length, one dead cycle between grants.
module rr_sel_4
  import rr_sel_4_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       rel,
  output logic       E,
  output logic       S1,
  output logic       S0,
  output logic       tmo
);

  localparam logic [CW-1:0] HM = CW'(HOLD_MAX);

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [IW-1:0] r_idx, w_idx_nx;
  logic [IW-1:0] r_last, w_last_nx;
  logic          r_tmo, w_tmo_nx;
  logic [IW-1:0] w_pick;
  logic          w_any;
  logic          w_timeout;
  logic          w_drop;
  logic          w_release;

  rr_pick_4 u_pick (
    .req  (req),
    .last (r_last),
    .idx  (w_pick),
    .any  (w_any)
  );

  assign w_timeout = (r_cnt == HM);
  assign w_drop    = ~req[r_idx];
  assign w_release = rel | w_drop | w_timeout;

  // State, counter, pointer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_last  <= RST_PTR;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_last  <= w_last_nx;
      r_tmo   <= w_tmo_nx;
    end
  end

  // Next-state logic: grant on any request, release on rel / dropped request / hold limit.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_last_nx  = r_last;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nx = GRANT;
          w_cnt_nx   = CW'(1);
          w_idx_nx   = w_pick;
        end else begin
          w_state_nx = IDLE;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
          w_last_nx  = r_idx;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // Timeout pulse only when the hold limit is the sole reason for the release.
  always_comb begin
    if (r_state == GRANT) begin
      w_tmo_nx = w_timeout & ~rel & ~w_drop;
    end else begin
      w_tmo_nx = 1'b0;
    end
  end

  assign E   = (r_state == GRANT);
  assign S1  = r_idx[1];
  assign S0  = r_idx[0];
  assign tmo = r_tmo;

endmodule

// File: tb/tb_rr_sel_4.sv
// Self-checking bench for rr_sel_4: cycle model plus directed grant-order expectations.
module tb_rr_sel_4;

  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       rel = 1'b0;
  logic       E, S1, S0, tmo;

  int n_chk = 0;
  int n_err = 0;

  rr_sel_4 #(.HOLD_MAX(HOLD), .CW(4)) dut (
    .clk(clk), .rst(rst), .req(req), .rel(rel),
    .E(E), .S1(S1), .S0(S0), .tmo(tmo)
  );

  always #5 clk = ~clk;

  // Reference model: grant flag, index, cycles held, last served index, timeout pulse.
  logic       m_e, n_e;
  logic [1:0] m_idx, n_idx, m_last, n_last;
  int         m_cnt, n_cnt;
  logic       m_tmo, n_tmo;
  logic       found, to_hit, dropped;

  always_comb begin
    n_e = m_e; n_idx = m_idx; n_last = m_last; n_cnt = m_cnt; n_tmo = 1'b0;
    found = 1'b0; to_hit = 1'b0; dropped = 1'b0;
    if (!m_e) begin
      for (int k = 1; k <= 4; k++) begin
        int p;
        p = (int'(m_last) + k) % 4;
        if (!found && req[p]) begin
          found = 1'b1;
          n_idx = 2'(p);
        end
      end
      if (found) begin
        n_e = 1'b1;
        n_cnt = 1;
      end
    end else begin
      to_hit  = (m_cnt >= HOLD);
      dropped = !req[m_idx];
      if (rel || dropped || to_hit) begin
        n_e = 1'b0;
        n_last = m_idx;
        n_cnt = 0;
        n_tmo = to_hit && !rel && !dropped;
      end else begin
        n_cnt = m_cnt + 1;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_e <= 1'b0; m_idx <= 2'd0; m_last <= 2'd3; m_cnt <= 0; m_tmo <= 1'b0;
    end else begin
      m_e <= n_e; m_idx <= n_idx; m_last <= n_last; m_cnt <= n_cnt; m_tmo <= n_tmo;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Observed grant log: index at each grant start, run length at each grant end, timeout pulses.
  int   g_log[$];
  int   r_log[$];
  int   tmo_cnt = 0;
  int   run = 0;
  logic prev_e = 1'b0;

  always @(posedge clk) begin
    #3;
    chk("E_vs_model", 32'(E), 32'(m_e));
    chk("S_vs_model", 32'({S1, S0}), 32'(m_idx));
    chk("tmo_vs_model", 32'(tmo), 32'(m_tmo));
    if (E && !prev_e) g_log.push_back(int'({S1, S0}));
    if (!E && prev_e) r_log.push_back(run);
    if (E) run = prev_e ? run + 1 : 1;
    if (tmo) tmo_cnt++;
    prev_e = E;
  end

  bit auto_rel = 1'b0;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rel = auto_rel && m_e && (m_cnt == 2);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; rel = 1'b0; auto_rel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    g_log.delete(); r_log.delete(); tmo_cnt = 0;
  endtask

  task automatic chk_q(input string nm, input int act[$], input int exp[$]);
    chk({nm, "_len"}, 32'(act.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < act.size(); i++)
      chk(nm, 32'(act[i]), 32'(exp[i]));
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_E", 32'(E), 32'd0);
    chk("rst_S", 32'({S1, S0}), 32'd0);
    chk("rst_tmo", 32'(tmo), 32'd0);

    // Single requester held: 8-cycle grants separated by a timeout dead cycle.
    do_reset();
    req = 4'b0001;
    step(20);
    chk_q("t1_order", g_log, '{0, 0, 0});
    chk_q("t1_runs", r_log, '{8, 8});
    chk("t1_tmo", 32'(tmo_cnt), 32'd2);

    // All requesting, release on second grant cycle: strict rotation.
    do_reset();
    req = 4'b1111; auto_rel = 1'b1;
    step(15);
    chk_q("t2_order", g_log, '{0, 1, 2, 3, 0});
    chk_q("t2_runs", r_log, '{2, 2, 2, 2, 2});
    chk("t2_tmo", 32'(tmo_cnt), 32'd0);

    // Sparse requesters 1 and 3 alternate.
    do_reset();
    req = 4'b1010; auto_rel = 1'b1;
    step(12);
    chk_q("t3_order", g_log, '{1, 3, 1, 3});
    chk_q("t3_runs", r_log, '{2, 2, 2, 2});

    // Dropping the granted request releases at once; re-raised req[2] waits its turn.
    do_reset();
    req = 4'b0100; auto_rel = 1'b1;
    step(1);
    req = 4'b1001;
    step(2);
    req = 4'b1101;
    step(9);
    chk_q("t4_order", g_log, '{2, 3, 0, 2, 3});
    chk_q("t4_runs", r_log, '{1, 2, 2, 2});
    chk("t4_tmo", 32'(tmo_cnt), 32'd0);

    // Asynchronous reset in the third grant cycle, then regrant to index 2.
    do_reset();
    req = 4'b0100;
    step(3);
    chk("t5_pre_E", 32'(E), 32'd1);
    chk("t5_pre_S", 32'({S1, S0}), 32'd2);
    rst = 1'b1;
    #1;
    chk("t5_async_E", 32'(E), 32'd0);
    chk("t5_async_S", 32'({S1, S0}), 32'd0);
    chk("t5_async_tmo", 32'(tmo), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1);
    chk("t5_post_E", 32'(E), 32'd1);
    chk("t5_post_S", 32'({S1, S0}), 32'd2);

    // Full load without release: every decoder line gets exactly HOLD cycles in turn.
    do_reset();
    req = 4'b1111;
    step(38);
    chk_q("t6_order", g_log, '{0, 1, 2, 3, 0});
    chk_q("t6_runs", r_log, '{HOLD, HOLD, HOLD, HOLD});
    chk("t6_tmo", 32'(tmo_cnt), 32'd4);

    req = 4'b0000;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
